lbp_hist: RTL and testbench

//   Downstream consumer of the LBP stage: snoops the lbp_addr/lbp_valid/lbp_data write stream,

---
 rtl/lbp_hist.sv | 143 ++++++++++++++
 tb/tb_lbp_hist.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_hist.sv
// rtl/lbp_hist.sv - 256-bin LBP code histogram with valid/ready clear-on-read dump
//
// Purpose: snoops the LBP write stream, counts codes of interior pixels into
// 256 saturating bins, then streams bins 0..255 out and clears each one as it
// is read, leaving the block ready for the next frame.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   lbp_valid/addr/data   LBP write stream ({row, col} address, code = bin)
//   lbp_finish            frame complete; starts the dump
//   hist_valid/ready      dump handshake
//   hist_bin/hist_count   current beat: bin index and its count
//   hist_done             one-cycle pulse after bin 255 is accepted
//   busy                  high while dumping
module lbp_hist #(
  parameter int IMG_LOG2  = 7,
  parameter int COUNT_W   = 14,
  parameter int BORDER_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lbp_valid,
  input  logic [2*IMG_LOG2-1:0] lbp_addr,
  input  logic [7:0]            lbp_data,
  input  logic                  lbp_finish,
  output logic                  hist_valid,
  input  logic                  hist_ready,
  output logic [7:0]            hist_bin,
  output logic [COUNT_W-1:0]    hist_count,
  output logic                  hist_done,
  output logic                  busy
);

  typedef enum logic [1:0] {ST_ACC, ST_DUMP, ST_DONE} state_t;

  localparam logic [IMG_LOG2-1:0] EDGE_MAX  = '1;
  localparam logic [COUNT_W-1:0]  COUNT_MAX = '1;

  state_t                  state_q, state_d;
  logic [COUNT_W-1:0]      bins_q [256];
  logic [COUNT_W-1:0]      bins_d [256];
  logic [7:0]              ptr_q, ptr_d;
  logic                    last_vld_q, last_vld_d;
  logic [2*IMG_LOG2-1:0]   last_addr_q, last_addr_d;
  logic                    hist_valid_q, hist_valid_d;
  logic [COUNT_W-1:0]      hist_count_q, hist_count_d;
  logic                    hist_done_q, hist_done_d;
  logic                    busy_q, busy_d;

  logic [IMG_LOG2-1:0]     row, col;
  logic                    border_ok;
  logic                    accept;
  logic [7:0]              ptr_nxt;

  assign row       = lbp_addr[2*IMG_LOG2-1:IMG_LOG2];
  assign col       = lbp_addr[IMG_LOG2-1:0];
  assign border_ok = (BORDER_EN == 0) ||
                     ((row != '0) && (row != EDGE_MAX) && (col != '0) && (col != EDGE_MAX));
  // The LBP stage may hold a write for several cycles; only a new address counts.
  assign accept    = lbp_valid && (!last_vld_q || (lbp_addr != last_addr_q)) && border_ok;
  assign ptr_nxt   = ptr_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    bins_d       = bins_q;
    ptr_d        = ptr_q;
    last_vld_d   = last_vld_q;
    last_addr_d  = last_addr_q;
    hist_valid_d = hist_valid_q;
    hist_count_d = hist_count_q;
    hist_done_d  = 1'b0;
    busy_d       = busy_q;

    unique case (state_q)
      ST_ACC: begin
        if (lbp_valid) begin
          last_addr_d = lbp_addr;
          last_vld_d  = 1'b1;
        end
        if (accept && (bins_q[lbp_data] != COUNT_MAX)) begin
          bins_d[lbp_data] = bins_q[lbp_data] + COUNT_W'(1);
        end
        if (lbp_finish) begin
          state_d      = ST_DUMP;
          ptr_d        = 8'd0;
          hist_valid_d = 1'b1;
          // Taken after the same-cycle write so a final write to bin 0 is seen.
          hist_count_d = bins_d[0];
          busy_d       = 1'b1;
        end
      end
      ST_DUMP: begin
        if (hist_valid_q && hist_ready) begin
          bins_d[ptr_q] = '0;
          if (ptr_q == 8'd255) begin
            state_d      = ST_DONE;
            hist_valid_d = 1'b0;
            busy_d       = 1'b0;
            hist_done_d  = 1'b1;
          end else begin
            ptr_d        = ptr_nxt;
            hist_count_d = bins_q[ptr_nxt];
          end
        end
      end
      ST_DONE: begin
        last_vld_d = 1'b0;
        state_d    = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ACC;
      for (int i = 0; i < 256; i++) bins_q[i] <= '0;
      ptr_q        <= 8'd0;
      last_vld_q   <= 1'b0;
      last_addr_q  <= '0;
      hist_valid_q <= 1'b0;
      hist_count_q <= '0;
      hist_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bins_q       <= bins_d;
      ptr_q        <= ptr_d;
      last_vld_q   <= last_vld_d;
      last_addr_q  <= last_addr_d;
      hist_valid_q <= hist_valid_d;
      hist_count_q <= hist_count_d;
      hist_done_q  <= hist_done_d;
      busy_q       <= busy_d;
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = ptr_q;
  assign hist_count = hist_count_q;
  assign hist_done  = hist_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lbp_hist.sv
// tb/tb_lbp_hist.sv - testbench for lbp_hist
module tb_lbp_hist;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = '0;
  logic [7:0]  lbp_data = '0;
  logic        lbp_finish = 1'b0;
  logic        hist_valid;
  logic        hist_ready = 1'b0;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic        hist_done;
  logic        busy;

  logic        s_valid_in = 1'b0;
  logic [13:0] s_addr = '0;
  logic [7:0]  s_data = '0;
  logic        s_finish = 1'b0;
  logic        s_hvalid;
  logic        s_ready = 1'b0;
  logic [7:0]  s_bin;
  logic [3:0]  s_count;
  logic        s_done;
  logic        s_busy;

  lbp_hist dut (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .lbp_finish(lbp_finish), .hist_valid(hist_valid),
    .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
    .hist_done(hist_done), .busy(busy)
  );

  lbp_hist #(.COUNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .lbp_valid(s_valid_in), .lbp_addr(s_addr),
    .lbp_data(s_data), .lbp_finish(s_finish), .hist_valid(s_hvalid),
    .hist_ready(s_ready), .hist_bin(s_bin), .hist_count(s_count),
    .hist_done(s_done), .busy(s_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: histogram of interior, non-repeated writes.
  int          m_bins [256];
  bit          m_last_vld = 0;
  logic [13:0] m_last_addr = '0;

  // Results captured from one dump.
  int          exp_bins [256];
  int          got_bins [256];
  int          beats, cycles, order_err, stall_err;
  logic        done_after, valid_after, busy_after, done_next;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit interior(input logic [13:0] a);
    int r, c;
    r = int'(a[13:7]);
    c = int'(a[6:0]);
    return (r >= 1) && (r <= 126) && (c >= 1) && (c <= 126);
  endfunction

  task automatic model_clear;
    for (int i = 0; i < 256; i++) m_bins[i] = 0;
    m_last_vld = 0;
  endtask

  task automatic do_write(input logic [13:0] a, input logic [7:0] d, input bit fin);
    lbp_valid  = 1'b1;
    lbp_addr   = a;
    lbp_data   = d;
    lbp_finish = fin;
    tick();
    if (interior(a) && !(m_last_vld && m_last_addr == a) && m_bins[d] < 16383)
      m_bins[d] = m_bins[d] + 1;
    m_last_vld  = 1;
    m_last_addr = a;
    lbp_valid   = 1'b0;
    lbp_finish  = 1'b0;
  endtask

  // mode 0: ready always, 1: ready on even cycles, 2: random ready.
  task automatic read_hist(input int mode, input bit pulse);
    int k, cyc;
    logic rdy, stalled;
    logic [13:0] prev;
    if (pulse) begin
      lbp_finish = 1'b1;
      tick();
      lbp_finish = 1'b0;
    end
    for (int i = 0; i < 256; i++) exp_bins[i] = m_bins[i];
    model_clear();
    k = 0; cyc = 0; order_err = 0; stall_err = 0; stalled = 1'b0; prev = '0;
    while (k < 256 && cyc < 2000) begin
      if (hist_valid !== 1'b1 || busy !== 1'b1 || hist_bin !== 8'(k)) order_err++;
      if (stalled && hist_count !== prev) stall_err++;
      got_bins[k] = int'(hist_count);
      prev = hist_count;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      hist_ready = rdy;
      lbp_valid  = 1'($urandom);
      lbp_addr   = 14'($urandom);
      lbp_data   = 8'($urandom);
      tick();
      cyc++;
      stalled = !rdy;
      if (rdy) k++;
    end
    hist_ready  = 1'b0;
    lbp_valid   = 1'b0;
    beats       = k;
    cycles      = cyc;
    done_after  = hist_done;
    valid_after = hist_valid;
    busy_after  = busy;
    tick();
    done_next   = hist_done;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({hist_valid, busy, hist_done} !== 3'b000 || hist_bin !== 8'd0 || hist_count !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b bin=%0d count=%0d, want all 0",
               hist_valid, busy, hist_done, hist_bin, hist_count);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_full_frame;
    int bad;
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++)
        do_write({7'(r), 7'(c)}, (r > 0 && r < 127 && c > 0 && c < 127) ? 8'h5A : 8'h00,
                 (r == 127 && c == 127));
    read_hist(0, 0);
    n_checks++;
    if (beats != 256 || order_err != 0) begin
      n_fail++;
      $display("FAIL full_beats: got beats=%0d order_err=%0d, want 256/0", beats, order_err);
    end
    n_checks++;
    if (got_bins[8'h5A] != 15876 || exp_bins[8'h5A] != 15876) begin
      n_fail++;
      $display("FAIL full_bin5a: got %0d model %0d, want 15876", got_bins[8'h5A], exp_bins[8'h5A]);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (i != 8'h5A && got_bins[i] != 0) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_others: got %0d nonzero bins, want 0", bad);
    end
    n_checks++;
    if (done_after !== 1'b1 || valid_after !== 1'b0 || busy_after !== 1'b0 || done_next !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: got done=%b valid=%b busy=%b done_next=%b, want 1 0 0 0",
               done_after, valid_after, busy_after, done_next);
    end
  endtask

  task automatic test_dedup;
    do_write(14'h0081, 8'h07, 0);
    do_write(14'h0081, 8'h07, 0);
    do_write(14'h0081, 8'h07, 0);
    do_write(14'h0082, 8'h07, 0);
    read_hist(0, 1);
    n_checks++;
    if (got_bins[7] != 2 || exp_bins[7] != 2) begin
      n_fail++;
      $display("FAIL dedup_bin7: got %0d model %0d, want 2", got_bins[7], exp_bins[7]);
    end
  endtask

  task automatic test_border;
    logic [13:0] edges [5];
    edges = '{14'h0000, 14'h007F, 14'h3F80, 14'h0080, 14'h3FFF};
    foreach (edges[i]) do_write(edges[i], 8'h03, 0);
    read_hist(0, 1);
    n_checks++;
    if (got_bins[3] != 0) begin
      n_fail++;
      $display("FAIL border_drop: got bin3=%0d, want 0", got_bins[3]);
    end
    do_write(14'h0081, 8'h03, 0);
    read_hist(0, 1);
    n_checks++;
    if (got_bins[3] != 1) begin
      n_fail++;
      $display("FAIL border_interior: got bin3=%0d, want 1", got_bins[3]);
    end
  endtask

  task automatic test_ready_toggle;
    int bad;
    for (int i = 0; i < 40; i++) do_write(14'($urandom), 8'($urandom_range(0, 7)), 0);
    read_hist(1, 1);
    n_checks++;
    if (beats != 256 || cycles != 511 || order_err != 0 || stall_err != 0) begin
      n_fail++;
      $display("FAIL toggle_beats: got beats=%0d cycles=%0d order_err=%0d stall_err=%0d, want 256/511/0/0",
               beats, cycles, order_err, stall_err);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (got_bins[i] != exp_bins[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL toggle_counts: got %0d bins differing from model, want 0", bad);
    end
    do_write(14'h0A0A, 8'h10, 0);
    read_hist(0, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (got_bins[i] != ((i == 8'h10) ? 1 : 0)) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clear_on_read: got %0d wrong bins (bin10=%0d), want 0 wrong, bin10=1",
               bad, got_bins[8'h10]);
    end
  endtask

  task automatic test_saturation;
    int bad;
    for (int i = 1; i <= 20; i++) begin
      s_valid_in = 1'b1;
      s_addr     = {7'd1, 7'(i)};
      s_data     = 8'h01;
      tick();
    end
    s_valid_in = 1'b0;
    s_finish   = 1'b1;
    tick();
    s_finish   = 1'b0;
    s_ready    = 1'b1;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (s_hvalid !== 1'b1 || s_bin !== 8'(k)) bad++;
      if (k == 1) begin
        n_checks++;
        if (s_count !== 4'd15) begin
          n_fail++;
          $display("FAIL sat_bin1: got %0d, want 15", s_count);
        end
      end else if (s_count !== 4'd0) bad++;
      tick();
    end
    s_ready = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sat_others: got %0d bad beats, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_dump;
    int cyc, bad;
    for (int i = 0; i < 60; i++) do_write(14'($urandom), 8'($urandom_range(0, 255)), 0);
    lbp_finish = 1'b1;
    tick();
    lbp_finish = 1'b0;
    hist_ready = 1'b1;
    cyc = 0;
    while (hist_bin !== 8'd100 && cyc < 400) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (hist_bin !== 8'd100) begin
      n_fail++;
      $display("FAIL mid_reach100: got bin=%0d, want 100", hist_bin);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (hist_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b busy=%b, want 0 0", hist_valid, busy);
    end
    hist_ready = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 80; i++) do_write(14'($urandom), 8'($urandom_range(95, 110)), 0);
    read_hist(0, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (got_bins[i] != exp_bins[i]) bad++;
    n_checks++;
    if (bad != 0 || beats != 256) begin
      n_fail++;
      $display("FAIL mid_fresh: got %0d wrong bins, %0d beats, want 0 and 256", bad, beats);
    end
  endtask

  task automatic test_random;
    int bad;
    logic [13:0] a;
    a = 14'h0101;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        lbp_valid = 1'b0;
        tick();
      end
      if ($urandom_range(0, 1) == 0) a = 14'($urandom);
      do_write(a, 8'($urandom_range(0, 15)), i == 399);
    end
    read_hist(2, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (got_bins[i] != exp_bins[i]) bad++;
    n_checks++;
    if (bad != 0 || beats != 256 || order_err != 0 || stall_err != 0) begin
      n_fail++;
      $display("FAIL random_frame: got %0d wrong bins, beats=%0d order_err=%0d stall_err=%0d, want 0/256/0/0",
               bad, beats, order_err, stall_err);
    end
    n_checks++;
    if (done_after !== 1'b1 || done_next !== 1'b0) begin
      n_fail++;
      $display("FAIL random_done: got done=%b then %b, want 1 then 0", done_after, done_next);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_frame();
    test_dedup();
    test_border();
    test_ready_toggle();
    test_saturation();
    test_reset_mid_dump();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
